// File: rtl/threshold_vote_detector.sv
// threshold_vote_detector
// Counts the set bits of an N-bit sample each valid cycle and flags a hit when the
// count reaches THRESH. Hit and miss runs are debounced over PERSIST consecutive
// valid samples. Bubbles (in_val=0) hold all state and do not break a run.
// Optional feature: define THRESHOLD_VOTE_DETECTOR_STICKY_EN to latch the detect
// flag once DET is reached; only rst clears it.
module threshold_vote_detector #(
    parameter int N       = 3,
    parameter int THRESH  = 2,
    parameter int PERSIST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_val,
    input  logic [N-1:0]               in,
    output logic                       out_val,
    output logic [$clog2(N+1)-1:0]     out_count,
    output logic                       out_det
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] TH_C    = CNT_W'(THRESH);
    localparam logic [RUN_W-1:0] PERS_C  = RUN_W'(PERSIST);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    if (N < 1) begin : g_bad_n
        $error("threshold_vote_detector: N must be >= 1");
    end
    if (THRESH < 1 || THRESH > N) begin : g_bad_thresh
        $error("threshold_vote_detector: THRESH must be in 1..N");
    end
    if (PERSIST < 1) begin : g_bad_persist
        $error("threshold_vote_detector: PERSIST must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_DET,
        S_REL
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [RUN_W-1:0]   w_run_nx;
    logic [RUN_W-1:0]   w_run_inc;
    logic [CNT_W-1:0]   w_pop;
    logic               w_hit;

    // Population count of the current sample and the threshold compare.
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pop = w_pop + CNT_W'(in[i]);
        end
        w_hit = (w_pop >= TH_C);
    end

    // run_cnt stays below PERSIST inside ARM/REL, so this increment cannot wrap.
    assign w_run_inc = r_run_cnt + RUN_ONE;

    // Next-state and run counter; the FSM only advances on valid samples.
    always_comb begin
        w_state_nx = r_state;
        w_run_nx   = r_run_cnt;
        if (in_val) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        if (PERSIST == 1) begin
                            w_state_nx = S_DET;
                        end else begin
                            w_state_nx = S_ARM;
                            w_run_nx   = RUN_ONE;
                        end
                    end
                end
                S_ARM: begin
                    if (w_hit) begin
                        if (w_run_inc == PERS_C) begin
                            w_state_nx = S_DET;
                            w_run_nx   = '0;
                        end else begin
                            w_run_nx   = w_run_inc;
                        end
                    end else begin
                        w_state_nx = S_IDLE;
                        w_run_nx   = '0;
                    end
                end
                S_DET: begin
`ifdef THRESHOLD_VOTE_DETECTOR_STICKY_EN
                    w_state_nx = S_DET;
`else
                    if (!w_hit) begin
                        if (PERSIST == 1) begin
                            w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_REL;
                            w_run_nx   = RUN_ONE;
                        end
                    end
`endif
                end
                S_REL: begin
                    if (!w_hit) begin
                        if (w_run_inc == PERS_C) begin
                            w_state_nx = S_IDLE;
                            w_run_nx   = '0;
                        end else begin
                            w_run_nx   = w_run_inc;
                        end
                    end else begin
                        w_state_nx = S_DET;
                        w_run_nx   = '0;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_run_nx   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset takes priority over in_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_run_cnt <= '0;
            out_val   <= 1'b0;
            out_count <= '0;
            out_det   <= 1'b0;
        end else begin
            out_val <= in_val;
            if (in_val) begin
                r_state   <= w_state_nx;
                r_run_cnt <= w_run_nx;
                out_count <= w_pop;
                out_det   <= (w_state_nx == S_DET) || (w_state_nx == S_REL);
            end
        end
    end

endmodule

// File: tb/tb_threshold_vote_detector.sv
// Scoreboard bench for threshold_vote_detector: three instances (PERSIST 3, 1, 2),
// directed vectors with hand-computed expectations pushed per instance queue.
module tb_threshold_vote_detector;

    localparam bit STICKY =
`ifdef THRESHOLD_VOTE_DETECTOR_STICKY_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [1:0] cnt;
        logic       det;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, va, ova, oda;
    logic       rst_b, vb, ovb, odb;
    logic       rst_c, vc, ovc, odc;
    logic [2:0] ina, inb, inc;
    logic [1:0] oca, ocb, occ;

    int checks   = 0;
    int failures = 0;

    logic [1:0] hold_cnt [3];
    logic       hold_det [3];

    threshold_vote_detector #(.N(3), .THRESH(2), .PERSIST(3)) u_a (
        .clk(clk), .rst(rst_a), .in_val(va), .in(ina),
        .out_val(ova), .out_count(oca), .out_det(oda)
    );
    threshold_vote_detector #(.N(3), .THRESH(2), .PERSIST(1)) u_b (
        .clk(clk), .rst(rst_b), .in_val(vb), .in(inb),
        .out_val(ovb), .out_count(ocb), .out_det(odb)
    );
    threshold_vote_detector #(.N(3), .THRESH(2), .PERSIST(2)) u_c (
        .clk(clk), .rst(rst_c), .in_val(vc), .in(inc),
        .out_val(ovc), .out_count(occ), .out_det(odc)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic mon(input int id, input logic r, input logic v,
                       input logic [1:0] c, input logic d);
        exp_t  e;
        int    sz;
        string tag;
        tag = (id == 0) ? "A" : (id == 1) ? "B" : "C";
        e   = '0;
        sz  = 0;
        if (r) begin
            chk({tag, "_rst_val"}, 32'(v), 0);
            chk({tag, "_rst_cnt"}, 32'(c), 0);
            chk({tag, "_rst_det"}, 32'(d), 0);
            hold_cnt[id] = '0;
            hold_det[id] = 1'b0;
        end else if (v === 1'b1) begin
            case (id)
                0: begin sz = qa.size(); if (sz != 0) e = qa.pop_front(); end
                1: begin sz = qb.size(); if (sz != 0) e = qb.pop_front(); end
                default: begin sz = qc.size(); if (sz != 0) e = qc.pop_front(); end
            endcase
            if (sz == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_underflow got=valid exp=no_pending_sample", tag);
            end else begin
                chk({tag, "_cnt"}, 32'(c), 32'(e.cnt));
                chk({tag, "_det"}, 32'(d), 32'(e.det));
                hold_cnt[id] = e.cnt;
                hold_det[id] = e.det;
            end
        end else begin
            chk({tag, "_val_idle"}, 32'(v), 0);
            chk({tag, "_hold_cnt"}, 32'(c), 32'(hold_cnt[id]));
            chk({tag, "_hold_det"}, 32'(d), 32'(hold_det[id]));
        end
    endtask

    // Drive one cycle on one instance; valid, non-reset samples push an expectation.
    task automatic drv(input int id, input logic r, input logic v, input logic [2:0] x,
                       input logic [1:0] ec, input logic ed);
        exp_t e;
        @(negedge clk);
        e.cnt = ec;
        e.det = ed;
        case (id)
            0: begin rst_a = r; va = v; ina = x; if (v && !r) qa.push_back(e); end
            1: begin rst_b = r; vb = v; inb = x; if (v && !r) qb.push_back(e); end
            default: begin rst_c = r; vc = v; inc = x; if (v && !r) qc.push_back(e); end
        endcase
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon(0, rst_a, ova, oca, oda);
            mon(1, rst_b, ovb, ocb, odb);
            mon(2, rst_c, ovc, occ, odc);
        end
    end

    localparam logic [1:0] B_CNT [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    localparam logic       B_DET [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic       B_DST [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        for (int i = 0; i < 3; i++) begin
            hold_cnt[i] = '0;
            hold_det[i] = 1'b0;
        end
        rst_a = 1'b1; va = 1'b0; ina = '0;
        rst_b = 1'b1; vb = 1'b0; inb = '0;
        rst_c = 1'b1; vc = 1'b0; inc = '0;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Instance A (PERSIST=3): rising run of hits, then a release run.
        drv(0, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(0, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(0, 0, 1, 3'b011, 2'd2, 1'b1);
        drv(0, 0, 1, 3'b000, 2'd0, 1'b1);
        drv(0, 0, 1, 3'b000, 2'd0, 1'b1);
        drv(0, 0, 1, 3'b000, 2'd0, STICKY);
        drv(0, 1, 0, 3'b000, 2'd0, 1'b0);

        // Bubbles do not break a streak; inputs during bubbles are ignored.
        drv(0, 0, 1, 3'b101, 2'd2, 1'b0);
        drv(0, 0, 0, 3'b111, 2'd0, 1'b0);
        drv(0, 0, 0, 3'b000, 2'd0, 1'b0);
        drv(0, 0, 1, 3'b110, 2'd2, 1'b0);
        drv(0, 0, 1, 3'b111, 2'd3, 1'b1);
        drv(0, 1, 0, 3'b000, 2'd0, 1'b0);

        // A miss inside the arming run restarts it.
        drv(0, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(0, 0, 1, 3'b001, 2'd1, 1'b0);
        drv(0, 0, 1, 3'b111, 2'd3, 1'b0);
        drv(0, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(0, 1, 0, 3'b000, 2'd0, 1'b0);

        // Reset mid-streak (with a valid hit present) discards the streak.
        drv(0, 0, 1, 3'b110, 2'd2, 1'b0);
        drv(0, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(0, 1, 1, 3'b111, 2'd0, 1'b0);
        drv(0, 0, 1, 3'b111, 2'd3, 1'b0);
        drv(0, 0, 1, 3'b111, 2'd3, 1'b0);
        drv(0, 0, 1, 3'b111, 2'd3, 1'b1);

        // Release interrupted by a hit, then a full release run.
        drv(0, 0, 1, 3'b100, 2'd1, 1'b1);
        drv(0, 0, 1, 3'b011, 2'd2, 1'b1);
        drv(0, 0, 1, 3'b000, 2'd0, 1'b1);
        drv(0, 0, 1, 3'b001, 2'd1, 1'b1);
        drv(0, 0, 1, 3'b010, 2'd1, STICKY);
        drv(0, 1, 0, 3'b000, 2'd0, 1'b0);
        drv(0, 0, 0, 3'b000, 2'd0, 1'b0);

        // Instance B (PERSIST=1): registered majority over all 8 inputs.
        for (int i = 0; i < 8; i++) begin
            drv(1, 0, 1, 3'(i), B_CNT[i], STICKY ? B_DST[i] : B_DET[i]);
        end
        drv(1, 0, 1, 3'b000, 2'd0, STICKY);
        drv(1, 1, 0, 3'b000, 2'd0, 1'b0);
        drv(1, 0, 0, 3'b000, 2'd0, 1'b0);

        // Instance C (PERSIST=2): detect, then five misses, then reset.
        drv(2, 0, 1, 3'b011, 2'd2, 1'b0);
        drv(2, 0, 1, 3'b111, 2'd3, 1'b1);
        drv(2, 0, 1, 3'b000, 2'd0, 1'b1);
        drv(2, 0, 1, 3'b001, 2'd1, STICKY);
        drv(2, 0, 1, 3'b010, 2'd1, STICKY);
        drv(2, 0, 1, 3'b100, 2'd1, STICKY);
        drv(2, 0, 1, 3'b000, 2'd0, STICKY);
        drv(2, 1, 0, 3'b000, 2'd0, 1'b0);
        drv(2, 0, 0, 3'b000, 2'd0, 1'b0);

        drv(2, 0, 0, 3'b000, 2'd0, 1'b0);
        drv(2, 0, 0, 3'b000, 2'd0, 1'b0);
        @(posedge clk);
        #2;
        chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
